// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage load/store engine. Loads and stores are moved
// one byte at a time over a req/ack bus while the pipeline is stalled.
// Optional build macro: MEM_MISALIGN_CHK_EN (misaligned halfword/word ops
// are rejected without bus traffic and flagged on misalign_err).
`ifndef REG_WIDTH
`define REG_WIDTH 5
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef ALU_OP_WIDTH
`define ALU_OP_WIDTH 8
`endif
`ifndef ZeroReg
`define ZeroReg 5'b00000
`endif
`ifndef ZeroWord
`define ZeroWord 32'h0000_0000
`endif
`ifndef ALU_NOP
`define ALU_NOP 8'h00
`endif
`ifndef ALU_ADD
`define ALU_ADD 8'h01
`endif
`ifndef ALU_LB
`define ALU_LB  8'h10
`define ALU_LH  8'h11
`define ALU_LW  8'h12
`define ALU_LBU 8'h13
`define ALU_LHU 8'h14
`define ALU_SB  8'h18
`define ALU_SH  8'h19
`define ALU_SW  8'h1A
`endif

module mem_access_unit #(
  parameter int TIMEOUT = 16
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [`REG_WIDTH-1:0]    mem_rd,
  input  logic                     mem_rd_op,
  input  logic [`DATA_WIDTH-1:0]   mem_rd_data,
  input  logic [`ALU_OP_WIDTH-1:0] mem_aluop,
  input  logic [`DATA_WIDTH-1:0]   mem_mem_addr,
  output logic [`REG_WIDTH-1:0]    wb_rd,
  output logic                     wb_rd_op,
  output logic [`DATA_WIDTH-1:0]   wb_rd_data,
  output logic                     stallreq_mem,
  output logic                     bus_req,
  output logic                     bus_we,
  output logic [`DATA_WIDTH-1:0]   bus_addr,
  output logic [7:0]               bus_wdata,
  input  logic                     bus_ack,
  input  logic [7:0]               bus_rdata,
  output logic                     bus_err
`ifdef MEM_MISALIGN_CHK_EN
  , output logic                   misalign_err
`endif
);

  localparam logic [31:0] TO = TIMEOUT;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t                   r_state, w_next;
  logic [1:0]               r_idx;
  logic [31:0]              r_wait;
  logic [`REG_WIDTH-1:0]    r_rd;
  logic                     r_rd_op;
  logic [`ALU_OP_WIDTH-1:0] r_op;
  logic [`DATA_WIDTH-1:0]   r_addr, r_wd, r_data;
  logic                     r_abort, r_mis;
  logic                     w_ack, w_mis;

  function automatic logic f_is_load(input logic [`ALU_OP_WIDTH-1:0] op);
    return op == `ALU_LB || op == `ALU_LH || op == `ALU_LW ||
           op == `ALU_LBU || op == `ALU_LHU;
  endfunction

  function automatic logic f_is_store(input logic [`ALU_OP_WIDTH-1:0] op);
    return op == `ALU_SB || op == `ALU_SH || op == `ALU_SW;
  endfunction

  // index of the final byte of the access (byte count minus one)
  function automatic logic [1:0] f_last(input logic [`ALU_OP_WIDTH-1:0] op);
    if (op == `ALU_LW || op == `ALU_SW) return 2'd3;
    if (op == `ALU_LH || op == `ALU_LHU || op == `ALU_SH) return 2'd1;
    return 2'd0;
  endfunction

  // misaligned halfword/word detection for the optional rejection path
`ifdef MEM_MISALIGN_CHK_EN
  assign w_mis = (f_last(mem_aluop) == 2'd1 && mem_mem_addr[0]) ||
                 (f_last(mem_aluop) == 2'd3 && mem_mem_addr[1:0] != 2'b00);
  assign misalign_err = (r_state == DONE) && r_mis;
`else
  assign w_mis = 1'b0;
`endif

  // next state, bus drive and write-back mux; reset forces every output low
  always_comb begin
    w_next       = r_state;
    wb_rd        = `ZeroReg;
    wb_rd_op     = 1'b0;
    wb_rd_data   = `ZeroWord;
    stallreq_mem = 1'b0;
    bus_req      = 1'b0;
    bus_we       = 1'b0;
    bus_addr     = `ZeroWord;
    bus_wdata    = 8'h00;
    bus_err      = 1'b0;
    w_ack        = 1'b0;
    if (!RST) begin
      case (r_state)
        IDLE: begin
          if (f_is_load(mem_aluop) || f_is_store(mem_aluop)) begin
            stallreq_mem = 1'b1;
            w_next       = w_mis ? DONE : BUSY;
          end else begin
            wb_rd      = mem_rd;
            wb_rd_op   = mem_rd_op;
            wb_rd_data = mem_rd_data;
          end
        end
        BUSY: begin
          stallreq_mem = 1'b1;
          if (TO != 32'd0 && r_wait == TO) begin
            bus_err = 1'b1;
            w_next  = DONE;
          end else begin
            bus_req   = 1'b1;
            bus_we    = f_is_store(r_op);
            bus_addr  = r_addr + {30'b0, r_idx};
            bus_wdata = r_wd[{r_idx, 3'b000} +: 8];
            if (bus_ack) begin
              w_ack = 1'b1;
              if (r_idx == f_last(r_op)) w_next = DONE;
            end
          end
        end
        DONE: begin
          w_next = IDLE;
          if (!r_abort && !r_mis && f_is_load(r_op)) begin
            wb_rd    = r_rd;
            wb_rd_op = r_rd_op;
            case (r_op)
              `ALU_LB:  wb_rd_data = {{24{r_data[7]}}, r_data[7:0]};
              `ALU_LH:  wb_rd_data = {{16{r_data[15]}}, r_data[15:0]};
              `ALU_LBU: wb_rd_data = {24'b0, r_data[7:0]};
              `ALU_LHU: wb_rd_data = {16'b0, r_data[15:0]};
              default:  wb_rd_data = r_data;
            endcase
          end
        end
        default: w_next = IDLE;
      endcase
    end
  end

  // state register plus latched request, byte index, wait counter and result
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= IDLE;
      r_idx   <= 2'd0;
      r_wait  <= 32'd0;
      r_rd    <= `ZeroReg;
      r_rd_op <= 1'b0;
      r_op    <= `ALU_NOP;
      r_addr  <= `ZeroWord;
      r_wd    <= `ZeroWord;
      r_data  <= `ZeroWord;
      r_abort <= 1'b0;
      r_mis   <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        IDLE: begin
          if (f_is_load(mem_aluop) || f_is_store(mem_aluop)) begin
            r_rd    <= mem_rd;
            r_rd_op <= mem_rd_op;
            r_op    <= mem_aluop;
            r_addr  <= mem_mem_addr;
            r_wd    <= mem_rd_data;
            r_data  <= `ZeroWord;
            r_idx   <= 2'd0;
            r_wait  <= 32'd0;
            r_abort <= 1'b0;
            r_mis   <= w_mis;
          end
        end
        BUSY: begin
          if (w_ack) begin
            if (f_is_load(r_op)) r_data[{r_idx, 3'b000} +: 8] <= bus_rdata;
            r_wait <= 32'd0;
            if (r_idx != f_last(r_op)) r_idx <= r_idx + 2'd1;
          end else if (bus_err) begin
            r_abort <= 1'b1;
          end else begin
            r_wait <= r_wait + 32'd1;
          end
        end
        DONE: begin
          r_idx  <= 2'd0;
          r_wait <= 32'd0;
          r_mis  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit (built with TIMEOUT = 4).
`ifndef REG_WIDTH
`define REG_WIDTH 5
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef ALU_OP_WIDTH
`define ALU_OP_WIDTH 8
`endif
`ifndef ALU_NOP
`define ALU_NOP 8'h00
`endif
`ifndef ALU_ADD
`define ALU_ADD 8'h01
`endif
`ifndef ALU_LB
`define ALU_LB  8'h10
`define ALU_LH  8'h11
`define ALU_LW  8'h12
`define ALU_LBU 8'h13
`define ALU_LHU 8'h14
`define ALU_SB  8'h18
`define ALU_SH  8'h19
`define ALU_SW  8'h1A
`endif

module tb_mem_access_unit;
  logic        CLK = 1'b0;
  logic        RST;
  logic [4:0]  mem_rd;
  logic        mem_rd_op;
  logic [31:0] mem_rd_data;
  logic [7:0]  mem_aluop;
  logic [31:0] mem_mem_addr;
  logic [4:0]  wb_rd;
  logic        wb_rd_op;
  logic [31:0] wb_rd_data;
  logic        stallreq_mem, bus_req, bus_we, bus_ack, bus_err;
  logic [31:0] bus_addr;
  logic [7:0]  bus_wdata, bus_rdata;
`ifdef MEM_MISALIGN_CHK_EN
  logic        misalign_err;
`endif

  always #5 CLK = ~CLK;

  mem_access_unit #(.TIMEOUT(4)) dut (
    .CLK(CLK), .RST(RST),
    .mem_rd(mem_rd), .mem_rd_op(mem_rd_op), .mem_rd_data(mem_rd_data),
    .mem_aluop(mem_aluop), .mem_mem_addr(mem_mem_addr),
    .wb_rd(wb_rd), .wb_rd_op(wb_rd_op), .wb_rd_data(wb_rd_data),
    .stallreq_mem(stallreq_mem),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata),
    .bus_err(bus_err)
`ifdef MEM_MISALIGN_CHK_EN
    , .misalign_err(misalign_err)
`endif
  );

  int checks = 0, errors = 0;

  // observations gathered by xfer
  int          n_stall, n_req, n_err, n_mis, log_n;
  logic [31:0] a_log [8];
  logic [7:0]  d_log [8];
  logic        we_log [8];
  logic [4:0]  c_rd;
  logic        c_op;
  logic [31:0] c_data;
  bit          c_fin;

  task automatic tick();
    @(posedge CLK); #1;
  endtask

  task automatic set_nop();
    mem_aluop = `ALU_NOP; mem_rd = 5'd0; mem_rd_op = 1'b0;
    mem_rd_data = 32'd0; mem_mem_addr = 32'd0;
  endtask

  // Present one op in the next IDLE cycle, act as the slave (ack after
  // 'delay' wait cycles, never if delay is large) and record what happens
  // up to and including the first cycle without a stall request.
  task automatic xfer(input logic [7:0] op, input logic [4:0] rd, input logic rdop,
                      input logic [31:0] data, input logic [31:0] addr,
                      input int delay, input logic [31:0] rbytes);
    int w;
    tick();
    mem_aluop = op; mem_rd = rd; mem_rd_op = rdop;
    mem_rd_data = data; mem_mem_addr = addr; bus_ack = 1'b0;
    n_stall = 0; n_req = 0; n_err = 0; n_mis = 0; log_n = 0; w = 0; c_fin = 0;
    for (int cyc = 0; cyc < 64 && !c_fin; cyc++) begin
      #1;
      if (bus_err) n_err++;
`ifdef MEM_MISALIGN_CHK_EN
      if (misalign_err) n_mis++;
`endif
      if (stallreq_mem) begin
        n_stall++;
        if (bus_req) begin
          n_req++;
          if (w == delay) begin
            bus_ack = 1'b1;
            bus_rdata = rbytes[8*(log_n%4) +: 8];
            if (log_n < 8) begin
              a_log[log_n] = bus_addr; d_log[log_n] = bus_wdata; we_log[log_n] = bus_we;
            end
            log_n++;
            w = 0;
          end else w++;
        end
        @(posedge CLK); #1;
        bus_ack = 1'b0;
      end else begin
        c_rd = wb_rd; c_op = wb_rd_op; c_data = wb_rd_data; c_fin = 1;
      end
    end
    set_nop();
    checks++;
    if (!c_fin) begin
      errors++;
      $display("FAIL xfer_done: op %h never left stall within 64 cycles", op);
    end
  endtask

  task automatic test_reset();
    RST = 1'b1; set_nop(); bus_ack = 1'b0; bus_rdata = 8'h00;
    #12;
    checks++;
    if ({stallreq_mem, bus_req, bus_we, bus_err, wb_rd_op} !== 5'b0) begin
      errors++; $display("FAIL reset_flags: got %b want 00000",
                         {stallreq_mem, bus_req, bus_we, bus_err, wb_rd_op});
    end
    checks++;
    if ({wb_rd, wb_rd_data, bus_addr, bus_wdata} !== 77'd0) begin
      errors++; $display("FAIL reset_data: rd=%h data=%h addr=%h wdata=%h",
                         wb_rd, wb_rd_data, bus_addr, bus_wdata);
    end
    @(negedge CLK); RST = 1'b0;
  endtask

  task automatic test_passthrough();
    tick();
    mem_aluop = `ALU_ADD; mem_rd = 5'd5; mem_rd_op = 1'b1; mem_rd_data = 32'h1234;
    bus_ack = 1'b1; bus_rdata = 8'hEE;   // stray ack while idle must be ignored
    #1;
    checks++;
    if ({wb_rd, wb_rd_op, wb_rd_data} !== {5'd5, 1'b1, 32'h1234}) begin
      errors++; $display("FAIL pass_wb: got rd=%0d op=%b data=%h want 5 1 00001234",
                         wb_rd, wb_rd_op, wb_rd_data);
    end
    checks++;
    if ({stallreq_mem, bus_req} !== 2'b00) begin
      errors++; $display("FAIL pass_idle: stall=%b req=%b want 0 0", stallreq_mem, bus_req);
    end
    tick();
    checks++;
    if ({stallreq_mem, bus_req, bus_err} !== 3'b000) begin
      errors++; $display("FAIL stray_ack: stall=%b req=%b err=%b want 000",
                         stallreq_mem, bus_req, bus_err);
    end
    bus_ack = 1'b0; set_nop();
  endtask

  task automatic test_lw();
    xfer(`ALU_LW, 5'd7, 1'b1, 32'h0, 32'h100, 0, 32'h12345678);
    checks++;
    if (n_stall !== 5) begin
      errors++; $display("FAIL lw_stall: got %0d cycles want 5", n_stall);
    end
    checks++;
    if ({a_log[0], a_log[1], a_log[2], a_log[3]} !== {32'h100, 32'h101, 32'h102, 32'h103}) begin
      errors++; $display("FAIL lw_addr: got %h %h %h %h want 100..103",
                         a_log[0], a_log[1], a_log[2], a_log[3]);
    end
    checks++;
    if (we_log[0] !== 1'b0 || log_n !== 4) begin
      errors++; $display("FAIL lw_bus: we=%b bytes=%0d want 0 4", we_log[0], log_n);
    end
    checks++;
    if ({c_rd, c_op, c_data} !== {5'd7, 1'b1, 32'h12345678}) begin
      errors++; $display("FAIL lw_wb: got rd=%0d op=%b data=%h want 7 1 12345678",
                         c_rd, c_op, c_data);
    end
  endtask

  task automatic test_lb_lbu();
    xfer(`ALU_LB, 5'd3, 1'b1, 32'h0, 32'h7, 0, 32'h00000080);
    checks++;
    if (c_data !== 32'hFFFFFF80 || a_log[0] !== 32'h7 || n_stall !== 2) begin
      errors++; $display("FAIL lb: data=%h addr=%h stall=%0d want ffffff80 7 2",
                         c_data, a_log[0], n_stall);
    end
    // back-to-back: issued in the IDLE cycle right after the previous DONE
    xfer(`ALU_LBU, 5'd4, 1'b1, 32'h0, 32'h7, 0, 32'h00000080);
    checks++;
    if ({c_rd, c_op, c_data} !== {5'd4, 1'b1, 32'h00000080}) begin
      errors++; $display("FAIL lbu: rd=%0d op=%b data=%h want 4 1 00000080",
                         c_rd, c_op, c_data);
    end
    xfer(`ALU_LH, 5'd6, 1'b1, 32'h0, 32'h40, 1, 32'h000080FE);
    checks++;
    if (c_data !== 32'hFFFF80FE || n_stall !== 5) begin
      errors++; $display("FAIL lh: data=%h stall=%0d want ffff80fe 5", c_data, n_stall);
    end
  endtask

  task automatic test_sh_delay();
    xfer(`ALU_SH, 5'd9, 1'b1, 32'hAABBCCDD, 32'h20, 3, 32'h0);
    checks++;
    if ({a_log[0], d_log[0], a_log[1], d_log[1]} !== {32'h20, 8'hDD, 32'h21, 8'hCC}) begin
      errors++; $display("FAIL sh_bytes: got %h@%h %h@%h want dd@20 cc@21",
                         d_log[0], a_log[0], d_log[1], a_log[1]);
    end
    checks++;
    if (n_req !== 8 || n_stall !== 9 || {we_log[0], we_log[1]} !== 2'b11) begin
      errors++; $display("FAIL sh_hold: req=%0d stall=%0d we=%b%b want 8 9 11",
                         n_req, n_stall, we_log[0], we_log[1]);
    end
    checks++;
    if ({c_rd, c_op, c_data} !== 38'd0) begin
      errors++; $display("FAIL sh_wb: rd=%0d op=%b data=%h want 0 0 0", c_rd, c_op, c_data);
    end
  endtask

  task automatic test_timeout();
    xfer(`ALU_LW, 5'd8, 1'b1, 32'h0, 32'h200, 1000, 32'h0);
    checks++;
    if (n_req !== 4 || n_err !== 1 || n_stall !== 6) begin
      errors++; $display("FAIL timeout: req=%0d err=%0d stall=%0d want 4 1 6",
                         n_req, n_err, n_stall);
    end
    checks++;
    if ({c_op, c_data} !== 33'd0) begin
      errors++; $display("FAIL timeout_wb: op=%b data=%h want 0 0", c_op, c_data);
    end
    tick();
    mem_aluop = `ALU_ADD; mem_rd = 5'd2; mem_rd_op = 1'b1; mem_rd_data = 32'h55;
    #1;
    checks++;
    if ({stallreq_mem, bus_req, bus_err, wb_rd_data} !== {3'b000, 32'h55}) begin
      errors++; $display("FAIL timeout_idle: stall=%b req=%b err=%b data=%h want 0 0 0 55",
                         stallreq_mem, bus_req, bus_err, wb_rd_data);
    end
    set_nop();
  endtask

  task automatic test_reset_mid();
    tick();
    mem_aluop = `ALU_LW; mem_rd = 5'd1; mem_rd_op = 1'b1; mem_mem_addr = 32'h300;
    tick();
    checks++;
    if (bus_req !== 1'b1) begin
      errors++; $display("FAIL rst_mid_busy: req=%b want 1", bus_req);
    end
    #2 RST = 1'b1;
    #1;
    checks++;
    if ({bus_req, stallreq_mem, wb_rd_op, wb_rd, wb_rd_data, bus_addr} !== 72'd0) begin
      errors++; $display("FAIL rst_mid: req=%b stall=%b op=%b rd=%0d data=%h addr=%h want all 0",
                         bus_req, stallreq_mem, wb_rd_op, wb_rd, wb_rd_data, bus_addr);
    end
    set_nop();
    @(negedge CLK); RST = 1'b0;
    xfer(`ALU_LBU, 5'd10, 1'b1, 32'h0, 32'h301, 0, 32'h000000A5);
    checks++;
    if ({c_rd, c_data, n_stall} !== {5'd10, 32'h000000A5, 32'd2}) begin
      errors++; $display("FAIL rst_recover: rd=%0d data=%h stall=%0d want 10 a5 2",
                         c_rd, c_data, n_stall);
    end
  endtask

`ifdef MEM_MISALIGN_CHK_EN
  task automatic test_misalign();
    xfer(`ALU_LW, 5'd11, 1'b1, 32'h0, 32'h102, 0, 32'h0);
    checks++;
    if (n_req !== 0 || n_stall !== 1 || n_mis !== 1 || c_op !== 1'b0 || c_data !== 32'd0) begin
      errors++; $display("FAIL misalign: req=%0d stall=%0d mis=%0d op=%b data=%h want 0 1 1 0 0",
                         n_req, n_stall, n_mis, c_op, c_data);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_passthrough();
    test_lw();
    test_lb_lbu();
    test_sh_delay();
    test_timeout();
    test_reset_mid();
`ifdef MEM_MISALIGN_CHK_EN
    test_misalign();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
